id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It detects load-use hazards and inserts bubbles, applies flushes and holds,
// forwards the WB result into the captured operands, and keeps saturating bubble/flush event counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [8:0]        id_ctrl,
  input  logic              wb_regWrite,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        RS_1,
  output logic [4:0]        RS_2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [8:0]        ex_ctrl,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int MemReadBit = 7;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              exValid_q, exValid_d;
  logic [XLEN-1:0]   exPc_q, exPc_d;
  logic [XLEN-1:0]   exImm_q, exImm_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   rs1Data_q, rs1Data_d;
  logic [XLEN-1:0]   rs2Data_q, rs2Data_d;
  logic [8:0]        ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;
  logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;

  logic hazard;
  logic doHold;
  logic doBubble;
  logic wbHitId1, wbHitId2;
  logic wbHitEx1, wbHitEx2;

  assign hazard = id_valid & exValid_q & ctrl_q[MemReadBit] & (rd_q != 5'd0) &
                  ((rd_q == id_rs1) | (rd_q == id_rs2));

  assign doHold   = ~flush & ex_stall;
  assign doBubble = ~flush & ~ex_stall & hazard;

  assign load_use_stall = doBubble;

  // x0 is never bypassed, so its operand always comes straight from the register file.
  assign wbHitId1 = wb_regWrite & (wb_rd != 5'd0) & (wb_rd == id_rs1);
  assign wbHitId2 = wb_regWrite & (wb_rd != 5'd0) & (wb_rd == id_rs2);
  assign wbHitEx1 = exValid_q & wb_regWrite & (wb_rd != 5'd0) & (wb_rd == rs1_q);
  assign wbHitEx2 = exValid_q & wb_regWrite & (wb_rd != 5'd0) & (wb_rd == rs2_q);

  always_comb begin
    exValid_d   = exValid_q;
    exPc_d      = exPc_q;
    exImm_d     = exImm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1Data_d   = rs1Data_q;
    rs2Data_d   = rs2Data_q;
    ctrl_d      = ctrl_q;
    bubbleCnt_d = bubbleCnt_q;
    flushCnt_d  = flushCnt_q;

    if (flush) begin
      exValid_d = 1'b0;
      ctrl_d    = 9'd0;
      if (flushCnt_q != {CNT_W{1'b1}}) flushCnt_d = flushCnt_q + CntOne;
    end else if (doHold) begin
      // A held instruction must still see a register written back while it waits.
      if (wbHitEx1) rs1Data_d = wb_data;
      if (wbHitEx2) rs2Data_d = wb_data;
    end else if (doBubble) begin
      exValid_d = 1'b0;
      ctrl_d    = 9'd0;
      rs1_d     = 5'd0;
      rs2_d     = 5'd0;
      rd_d      = 5'd0;
      if (bubbleCnt_q != {CNT_W{1'b1}}) bubbleCnt_d = bubbleCnt_q + CntOne;
    end else begin
      exValid_d = id_valid;
      exPc_d    = id_pc;
      exImm_d   = id_imm;
      rs1_d     = id_rs1;
      rs2_d     = id_rs2;
      rd_d      = id_rd;
      rs1Data_d = wbHitId1 ? wb_data : id_rs1_data;
      rs2Data_d = wbHitId2 ? wb_data : id_rs2_data;
      ctrl_d    = id_valid ? id_ctrl : 9'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exValid_q   <= 1'b0;
      exPc_q      <= '0;
      exImm_q     <= '0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      rs1Data_q   <= '0;
      rs2Data_q   <= '0;
      ctrl_q      <= 9'd0;
      bubbleCnt_q <= '0;
      flushCnt_q  <= '0;
    end else begin
      exValid_q   <= exValid_d;
      exPc_q      <= exPc_d;
      exImm_q     <= exImm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1Data_q   <= rs1Data_d;
      rs2Data_q   <= rs2Data_d;
      ctrl_q      <= ctrl_d;
      bubbleCnt_q <= bubbleCnt_d;
      flushCnt_q  <= flushCnt_d;
    end
  end

  assign ex_valid    = exValid_q;
  assign ex_pc       = exPc_q;
  assign ex_imm      = exImm_q;
  assign RS_1        = rs1_q;
  assign RS_2        = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_rs1_data = rs1Data_q;
  assign ex_rs2_data = rs2Data_q;
  assign ex_ctrl     = ctrl_q;
  assign bubble_cnt  = bubbleCnt_q;
  assign flush_cnt   = flushCnt_q;

endmodule
